// File: rtl/mips_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// State encoding, reset PC and PC step live here.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

   localparam logic [31:0] PC_START_DEFAULT = 32'h8002_0000;
   localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

   function automatic logic [31:0] word_align(
      input logic [31:0] a
   );
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read bus between fetch and memory.
// One request in flight; response returns on mem_rd_valid.
interface fetch_if;

   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_rd_valid;
   logic [31:0] mem_rd_data;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_ready,
      input  mem_rd_valid,
      input  mem_rd_data
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_ready,
      output mem_rd_valid,
      output mem_rd_data
   );

endinterface

// File: rtl/pc_counter.sv
// Fetch PC register: sequential step, natural 32-bit wrap,
// and word-aligned redirect, with redirect taking priority.
module pc_counter
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_START = PC_START_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        inc,
   input  logic [31:0] target,
   output logic [31:0] pc_reg,
   output logic [31:0] pc_next
);

   always_comb begin
      pc_next = pc_reg;
      unique case (1'b1)
         load:    pc_next = word_align(target);
         inc:     pc_next = pc_reg + PC_STEP;
         default: pc_next = pc_reg;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_reg <= PC_START;
      end else begin
         pc_reg <= pc_next;
      end
   end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: single-outstanding read FSM with
// decode back-pressure and branch redirect.
module fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_START = PC_START_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   fetch_if.master     mem,
   output logic [31:0] insn,
   output logic [31:0] pc,
   output logic        enable_decode
);

   fetch_state_t state;
   logic         discard;
   logic [31:0]  held;
   logic [31:0]  pc_reg;
   logic [31:0]  pc_next;
   logic         deliver;
   logic [31:0]  word_in;

   // A redirect always wins, so it suppresses delivery.
   always_comb begin
      deliver = 1'b0;
      if (!branch_taken) begin
         unique case (state)
            WAIT: deliver = mem.mem_rd_valid
                          & ~stall & ~discard;
            HOLD: deliver = ~stall;
            default: deliver = 1'b0;
         endcase
      end
   end

   assign word_in = (state == HOLD) ? held
                                    : mem.mem_rd_data;

   pc_counter #(
      .PC_START (PC_START),
      .PC_STEP  (PC_STEP)
   ) u_pc (
      .clock   (clock),
      .reset   (reset),
      .load    (branch_taken),
      .inc     (deliver),
      .target  (branch_target),
      .pc_reg  (pc_reg),
      .pc_next (pc_next)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         discard       <= 1'b0;
         held          <= 32'h0;
         insn          <= 32'h0;
         pc            <= 32'h0;
         enable_decode <= 1'b0;
         mem.mem_rd_en <= 1'b0;
         mem.mem_addr  <= 32'h0;
      end else begin
         enable_decode <= 1'b0;
         unique case (state)
            IDLE: begin
               state         <= REQ;
               mem.mem_rd_en <= 1'b1;
               mem.mem_addr  <= pc_next;
            end
            REQ: begin
               if (mem.mem_ready) begin
                  state         <= WAIT;
                  mem.mem_rd_en <= 1'b0;
                  discard       <= branch_taken;
               end else begin
                  mem.mem_addr  <= pc_next;
               end
            end
            WAIT: begin
               if (mem.mem_rd_valid) begin
                  if (branch_taken || discard || !stall) begin
                     state         <= REQ;
                     discard       <= 1'b0;
                     mem.mem_rd_en <= 1'b1;
                     mem.mem_addr  <= pc_next;
                  end else begin
                     held  <= mem.mem_rd_data;
                     state <= HOLD;
                  end
               end else if (branch_taken) begin
                  discard <= 1'b1;
               end
            end
            HOLD: begin
               if (branch_taken || !stall) begin
                  state         <= REQ;
                  mem.mem_rd_en <= 1'b1;
                  mem.mem_addr  <= pc_next;
               end
            end
            default: state <= IDLE;
         endcase
         if (deliver) begin
            enable_decode <= 1'b1;
            insn          <= word_in;
            pc            <= pc_reg;
         end
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios, then random traffic
// checked against a transaction-level PC/instruction model.
module tb_fetch;
   import mips_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] insn;
   logic [31:0] pc;
   logic        enable_decode;

   fetch_if mem_bus ();

   fetch u_dut (
      .clock         (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .mem           (mem_bus),
      .insn          (insn),
      .pc            (pc),
      .enable_decode (enable_decode)
   );

   logic        w_reset;
   logic [31:0] w_insn;
   logic [31:0] w_pc;
   logic        w_en;

   fetch_if wbus ();

   fetch #(
      .PC_START (32'hFFFF_FFFC)
   ) u_wrap (
      .clock         (clk),
      .reset         (w_reset),
      .stall         (1'b0),
      .branch_taken  (1'b0),
      .branch_target (32'h0),
      .mem           (wbus),
      .insn          (w_insn),
      .pc            (w_pc),
      .enable_decode (w_en)
   );

   int chk_n = 0;
   int err_n = 0;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      chk_n++;
      if (got !== exp) begin
         err_n++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(
      input logic [31:0] a
   );
      return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
   endfunction

   // reference model and memory state
   logic [31:0] exp_pc;
   bit          outst;
   bit          late_pend;
   int          cnt;
   logic [31:0] resp_addr;
   int          lat_lo, lat_hi;
   int          rdy_pct;
   bit          spur;
   int          deliveries;
   int          since;
   logic        pre_en, pre_rd;
   logic [31:0] pre_addr;

   task automatic cyc();
      logic v;
      logic r;
      if (late_pend) begin
         mem_bus.mem_rd_valid = 1'b1;
         mem_bus.mem_rd_data  = mem_word(resp_addr);
      end else if (outst && cnt == 0) begin
         mem_bus.mem_rd_valid = 1'b1;
         mem_bus.mem_rd_data  = mem_word(resp_addr);
      end else if (!outst && spur &&
                   $urandom_range(0, 7) == 0) begin
         mem_bus.mem_rd_valid = 1'b1;
         mem_bus.mem_rd_data  = $urandom;
      end else begin
         mem_bus.mem_rd_valid = 1'b0;
         mem_bus.mem_rd_data  = $urandom;
      end
      mem_bus.mem_ready = late_pend ? 1'b0 :
         ($urandom_range(0, 99) < rdy_pct);
      pre_en   = enable_decode;
      pre_rd   = mem_bus.mem_rd_en;
      pre_addr = mem_bus.mem_addr;
      v = mem_bus.mem_rd_valid;
      r = mem_bus.mem_ready;
      @(posedge clk);
      #1;
      since++;
      if (reset) begin
         late_pend = outst;
         outst     = 1'b0;
         exp_pc    = PC_START_DEFAULT;
         check("rst_en",   enable_decode, 0);
         check("rst_insn", insn, 0);
         check("rst_pc",   pc, 0);
         check("rst_rd",   mem_bus.mem_rd_en, 0);
         check("rst_addr", mem_bus.mem_addr, 0);
      end else begin
         late_pend = 1'b0;
         if (outst) begin
            check("rd_in_wait", pre_rd, 0);
            if (v) outst = 1'b0;
            else   cnt--;
         end else if (pre_rd && r) begin
            if (!branch_taken)
               check("req_addr", pre_addr, exp_pc);
            outst     = 1'b1;
            cnt       = $urandom_range(lat_lo, lat_hi);
            resp_addr = pre_addr;
         end
         if (branch_taken) begin
            check("br_no_pulse", enable_decode, 0);
            exp_pc = branch_target & ~32'h3;
         end else if (enable_decode) begin
            check("pulse_gap",  pre_en, 0);
            check("pulse_pc",   pc, exp_pc);
            check("pulse_insn", insn, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
            since = 0;
         end
      end
   endtask

   logic        w_pend, w_req;
   logic [31:0] w_a, w_addr;
   logic [31:0] wq_pc[$];
   logic [31:0] wq_insn[$];

   initial begin
      w_reset = 1'b1;
      w_pend  = 1'b0;
      w_addr  = 32'h0;
      wbus.mem_ready    = 1'b1;
      wbus.mem_rd_valid = 1'b0;
      wbus.mem_rd_data  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      w_reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wbus.mem_rd_valid = w_pend;
         wbus.mem_rd_data  = ~w_addr;
         w_req = wbus.mem_rd_en;
         w_a   = wbus.mem_addr;
         @(posedge clk);
         #1;
         if (w_en) begin
            wq_pc.push_back(w_pc);
            wq_insn.push_back(w_insn);
         end
         w_pend = w_req;
         w_addr = w_a;
      end
   end

   logic [6:0] pat;

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      exp_pc = PC_START_DEFAULT;
      outst = 0; late_pend = 0; cnt = 0;
      resp_addr = 0;
      lat_lo = 0; lat_hi = 0;
      rdy_pct = 100; spur = 0;
      deliveries = 0; since = 0;
      cyc();
      cyc();
      reset = 1'b0;

      // back-to-back fetch, 1-cycle memory
      pat = 7'b1010100;
      for (int i = 0; i < 7; i++) begin
         cyc();
         check("seq_en", enable_decode, pat[i]);
         if (i == 0)
            check("first_addr", mem_bus.mem_addr,
                  PC_START_DEFAULT);
      end
      check("seq_pc3", pc, 32'h8002_0008);

      // decode stall while the word is returned
      cyc();
      stall = 1'b1;
      repeat (3) begin
         cyc();
         check("hold_en", enable_decode, 0);
         check("hold_rd", mem_bus.mem_rd_en, 0);
      end
      stall = 1'b0;
      cyc();
      check("hold_rel_en", enable_decode, 1);
      check("hold_rel_pc", pc, 32'h8002_000C);
      lat_lo = 1; lat_hi = 1;
      cyc();
      check("no_dup", enable_decode, 0);
      check("insn_kept", insn, mem_word(32'h8002_000C));

      // redirect while waiting for the response
      branch_taken  = 1'b1;
      branch_target = 32'h8002_0103;
      cyc();
      branch_taken = 1'b0;
      check("wait_br_en", enable_decode, 0);
      cyc();
      check("drop_en", enable_decode, 0);
      check("drop_rd", mem_bus.mem_rd_en, 1);
      check("drop_addr", mem_bus.mem_addr, 32'h8002_0100);
      lat_lo = 0; lat_hi = 0;
      cyc();
      cyc();
      check("br_en", enable_decode, 1);
      check("br_pc", pc, 32'h8002_0100);

      // redirect coinciding with the response
      cyc();
      branch_taken  = 1'b1;
      branch_target = 32'h1234_5678;
      cyc();
      branch_taken = 1'b0;
      check("same_en", enable_decode, 0);
      check("same_rd", mem_bus.mem_rd_en, 1);
      check("same_addr", mem_bus.mem_addr, 32'h1234_5678);
      cyc();
      cyc();
      check("same_pulse", enable_decode, 1);
      check("same_pc", pc, 32'h1234_5678);

      // reset with a read in flight, late response after
      lat_lo = 2; lat_hi = 2;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      check("late_en", enable_decode, 0);
      check("late_rd", mem_bus.mem_rd_en, 1);
      check("late_addr", mem_bus.mem_addr, PC_START_DEFAULT);
      lat_lo = 0; lat_hi = 0;
      cyc();
      cyc();
      check("restart_en", enable_decode, 1);
      check("restart_pc", pc, PC_START_DEFAULT);

      // random traffic
      rdy_pct = 70; lat_lo = 0; lat_hi = 2; spur = 1;
      deliveries = 0; since = 0;
      for (int i = 0; i < 4000; i++) begin
         stall = ($urandom_range(0, 2) == 0);
         branch_taken  = ($urandom_range(0, 11) == 0);
         branch_target = $urandom;
         reset = ($urandom_range(0, 199) == 0);
         cyc();
         if (since > 300) begin
            check("stuck_cycles", since, 0);
            since = 0;
         end
      end
      reset = 1'b0;
      branch_taken = 1'b0;
      stall = 1'b0;
      check("rand_deliveries", deliveries >= 200, 1);

      check("wrap_cnt", wq_pc.size() >= 2, 1);
      if (wq_pc.size() >= 2) begin
         check("wrap_pc0", wq_pc[0], 32'hFFFF_FFFC);
         check("wrap_pc1", wq_pc[1], 32'h0000_0000);
         check("wrap_in0", wq_insn[0], ~32'hFFFF_FFFC);
         check("wrap_in1", wq_insn[1], ~32'h0000_0000);
      end

      $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
      $finish;
   end

endmodule
